// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with configurable access latency.
// One outstanding request; valid/ready handshakes on both the request and response sides.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              lat_we_q, lat_we_d;
    logic [31:0]       lat_addr_q, lat_addr_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic [3:0]        lat_be_q, lat_be_d;

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              do_access;
    logic              mem_we;

    logic [31:0]       mem [DEPTH];

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With zero wait cycles the access happens on the accept edge, so it must use the live request.
    always_comb begin
        acc_we    = lat_we_q;
        acc_addr  = lat_addr_q;
        acc_wdata = lat_wdata_q;
        acc_be    = lat_be_q;
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
        acc_idx = acc_addr[IDX_W+1:2];
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_be_d    = lat_be_q;
        do_access   = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    lat_we_d    = req_we;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    lat_be_d    = req_be;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (!acc_err && !acc_we) ? mem[acc_idx] : '0;
        end
    end

    assign mem_we = do_access && acc_we && !acc_err;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_be_q    <= lat_be_d;
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait cycles, one with zero.
module tb_dmem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset, reset0;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset0),
        .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request and returns at the negedge just after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        check("accepted", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_rsp(output logic [31:0] rdata, output logic err);
        for (int i = 0; i < W; i++) begin
            check("lat_idle", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("lat_valid", 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_valid", 32'(rsp_valid), 32'd0);
        check("hs_rdata", rsp_rdata, 32'd0);
        check("hs_err", 32'(rsp_err), 32'd0);
        check("hs_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        issue(we, addr, wdata, be);
        wait_rsp(rd, er);
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        take_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        reset = 1'b0; reset0 = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;

        // Reset held for three cycles, then released.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_valid", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        #1 check("rel_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rel_ready_high", 32'(req_ready), 32'd1);

        // Full-word store and load back.
        transact("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        transact("ld_word", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte mask and empty mask.
        transact("st_byte", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        transact("ld_byte", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
        transact("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        transact("ld_be0", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

        // Faults; idx 64 must not alias onto word 0, idx 63 is the last valid word.
        transact("st_w0", 1'b1, 32'h0, 32'h11223344, 4'hF, 32'h0, 1'b0);
        transact("ld_mis", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
        transact("st_oor", 1'b1, 32'h100, 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1);
        transact("ld_w0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h11223344, 1'b0);
        transact("st_last", 1'b1, 32'hFC, 32'h5A5AA5A5, 4'hF, 32'h0, 1'b0);
        transact("ld_last", 1'b0, 32'hFC, 32'h0, 4'h0, 32'h5A5AA5A5, 1'b0);

        // Backpressure with varying requests held on the input.
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(rd, er);
        check("bp_first", rd, 32'hDEADBEAA);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_we    = i[0];
            req_addr  = 32'h10;
            req_wdata = 32'hFFFF0000 | 32'(i);
            req_be    = 4'hF;
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hDEADBEAA);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        req_we    = 1'b0;
        req_addr  = 32'h10;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_hs_ready", 32'(req_ready), 32'd1);
        check("bp_hs_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_accept", 32'(req_ready), 32'd0);
        wait_rsp(rd, er);
        check("bp_next_rdata", rd, 32'hDEADBEAA);
        take_rsp();

        // Reset during WAIT drops the store.
        transact("st_clr20", 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 32'h12345678, 4'hF);
        reset = 1'b0;
        @(negedge clk);
        check("wr_rst_ready", 32'(req_ready), 32'd0);
        check("wr_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("wr_rel_ready", 32'(req_ready), 32'd1);
        transact("ld_20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset during RESP keeps the performed store.
        issue(1'b1, 32'h24, 32'hCAFEF00D, 4'hF);
        wait_rsp(rd, er);
        reset = 1'b0;
        #1 check("rr_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        transact("ld_24", 1'b0, 32'h24, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

        // Zero-wait instance: response on the accept edge.
        reset  = 1'b0;
        reset0 = 1'b1;
        @(negedge clk);
        check("z_ready", 32'(req_ready0), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        check("z_st_valid", 32'(rsp_valid0), 32'd1);
        check("z_st_err", 32'(rsp_err0), 32'd0);
        check("z_st_rdata", rsp_rdata0, 32'd0);
        check("z_st_ready", 32'(req_ready0), 32'd0);
        reset0 = 1'b0;
        @(negedge clk);
        reset0 = 1'b1;
        @(negedge clk);
        check("z_rel_ready", 32'(req_ready0), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        check("z_ld_valid", 32'(rsp_valid0), 32'd1);
        check("z_ld_rdata", rsp_rdata0, 32'h12345678);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("z_hs_valid", 32'(rsp_valid0), 32'd0);
        check("z_hs_ready", 32'(req_ready0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
